// File: rtl/counter_timer_arbiter.sv
// counter_timer_arbiter
// Shares one up-counting interval timer between N_REQ requesters. A winner is
// picked in IDLE. The counter runs from 0 up to that winner's latched terminal
// count, and then a one-cycle done pulse goes back to the winner.
// Optional build macro: FIXED_PRIORITY_EN selects lowest-index-wins arbitration
// instead of round-robin. When it is set, there is no rr_ptr.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no owner; counter held at 0; arbitrating pending requests
// RUN   | owner holds grant; counter steps until it equals term
// DONE  | done pulse cycle; grant and counter held, then release
module counter_timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] len,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [N_REQ-1:0]       done,
  output logic [CNT_W-1:0]       cnt,
  output logic [2:0]             owner
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   grant_nxt, done_nxt;
  logic               busy_nxt;
  logic [CNT_W-1:0]   cnt_nxt, term, term_nxt;
  logic [2:0]         owner_nxt;

  logic [2:0]         win_idx;
  logic [N_REQ-1:0]   win_onehot;
  logic [CNT_W-1:0]   win_len;
  logic               req_owner;

`ifndef FIXED_PRIORITY_EN
  logic [2:0]         rr_ptr, rr_nxt;
  logic [2:0]         owner_inc;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [3:0]         sum;
`endif

  // Owner's request still present; grant is one-hot on the owner while RUN.
  assign req_owner = |(req & grant);

`ifndef FIXED_PRIORITY_EN
  // Index after the current owner, wrapping at N_REQ.
  assign owner_inc = (owner == 3'(N_REQ-1)) ? 3'd0 : owner + 3'd1;
`endif

  // Winner selection, the one-hot form of the winner, and the winner's terminal count.
  always_comb begin
    win_idx    = '0;
    win_onehot = '0;
    win_len    = '0;
`ifdef FIXED_PRIORITY_EN
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (req[i]) win_idx = 3'(i);
    end
`else
    // Rotate so that bit 0 is rr_ptr; the lowest set bit is the next in turn.
    req_dbl = {req, req} >> rr_ptr;
    req_rot = req_dbl[N_REQ-1:0];
    sum     = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sum = {1'b0, rr_ptr} + 4'(k);
        if (sum >= 4'(N_REQ)) sum = sum - 4'(N_REQ);
        win_idx = sum[2:0];
      end
    end
`endif
    for (int i = 0; i < N_REQ; i++) begin
      win_onehot[i] = (win_idx == 3'(i));
      if (win_idx == 3'(i)) win_len = len[i*CNT_W +: CNT_W];
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    done_nxt  = '0;
    busy_nxt  = busy;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    term_nxt  = term;
`ifndef FIXED_PRIORITY_EN
    rr_nxt    = rr_ptr;
`endif
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (|req) begin
          state_nxt = S_RUN;
          grant_nxt = win_onehot;
          owner_nxt = win_idx;
          term_nxt  = win_len;
          busy_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        // Abort wins over completion in the same cycle.
        if (!req_owner) begin
          state_nxt = S_IDLE;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
`ifndef FIXED_PRIORITY_EN
          rr_nxt    = owner_inc;
`endif
        end else if (cnt == term) begin
          // Terminal is checked before incrementing, so the counter never wraps.
          state_nxt = S_DONE;
          done_nxt  = grant;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
`ifndef FIXED_PRIORITY_EN
        rr_nxt    = owner_inc;
`endif
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
      cnt    <= '0;
      owner  <= '0;
      term   <= '0;
`ifndef FIXED_PRIORITY_EN
      rr_ptr <= '0;
`endif
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      done   <= done_nxt;
      busy   <= busy_nxt;
      cnt    <= cnt_nxt;
      owner  <= owner_nxt;
      term   <= term_nxt;
`ifndef FIXED_PRIORITY_EN
      rr_ptr <= rr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// Directed bench for counter_timer_arbiter (N_REQ=4, CNT_W=4).
// Inputs change 1 time unit after a rising edge. Outputs are checked at the same point.
module tb_counter_timer_arbiter;
  localparam int N_REQ = 4;
  localparam int CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] len;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic [N_REQ-1:0]       done;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             owner;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_timer_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .grant (grant),
    .busy  (busy),
    .done  (done),
    .cnt   (cnt),
    .owner (owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".grant"}, 32'(grant), 32'd0);
    chk({tag, ".done"},  32'(done),  32'd0);
    chk({tag, ".busy"},  32'(busy),  32'd0);
    chk({tag, ".cnt"},   32'(cnt),   32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_own;
    rst = 1'b1;
    req = 4'b1111;
    len = '0;

    // Reset held with all requests asserted.
    step();
    chk_idle("rst1");
    chk("rst1.owner", 32'(owner), 32'd0);
    step();
    chk_idle("rst2");
    chk("rst2.owner", 32'(owner), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_rel.grant", 32'(grant), 32'h1);
    chk("rst_rel.busy",  32'(busy),  32'd1);
    req = '0;
    step();
    chk_idle("rst_rel_abort");

    // Single request, len[0]=3.
    do_reset();
    len = 16'h0003;
    req = 4'b0001;
    step();
    chk("single.grant", 32'(grant), 32'h1);
    chk("single.cnt0",  32'(cnt),   32'd0);
    chk("single.busy",  32'(busy),  32'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("single.cnt",  32'(cnt),  32'(k));
      chk("single.done", 32'(done), 32'd0);
    end
    step();
    chk("single.done_pulse", 32'(done),  32'h1);
    chk("single.cnt_hold",   32'(cnt),   32'd3);
    chk("single.grant_hold", 32'(grant), 32'h1);
    chk("single.busy_done",  32'(busy),  32'd1);
    req = '0;
    step();
    chk_idle("single.end");

    // Contention: req 0 and 2 held, all lengths 1.
    do_reset();
    len = 16'h1111;
    req = 4'b0101;
    for (int g = 0; g < 4; g++) begin
`ifdef FIXED_PRIORITY_EN
      exp_own = 0;
`else
      exp_own = (g % 2 == 1) ? 2 : 0;
`endif
      step();
      chk("rr.owner", 32'(owner), 32'(exp_own));
      chk("rr.grant", 32'(grant), 32'(1 << exp_own));
      step();
      step();
      chk("rr.done", 32'(done), 32'(1 << exp_own));
      chk("rr.cnt",  32'(cnt),  32'd1);
      step();
      chk("rr.release", 32'(grant), 32'd0);
    end
    req = '0;
    step();

    // Zero length on requester 1.
    do_reset();
    len = 16'h0000;
    req = 4'b0010;
    step();
    chk("zero.grant", 32'(grant), 32'h2);
    chk("zero.owner", 32'(owner), 32'd1);
    step();
    chk("zero.done", 32'(done), 32'h2);
    chk("zero.cnt",  32'(cnt),  32'd0);
    req = '0;
    step();
    chk_idle("zero.end");
    chk("zero.owner_hold", 32'(owner), 32'd1);

    // Abort at cnt=5 with req[0] pending.
    do_reset();
    len = 16'hF000;
    req = 4'b1000;
    step();
    chk("abort.grant", 32'(grant), 32'h8);
    req = 4'b1001;
    for (int k = 0; k < 5; k++) step();
    chk("abort.cnt5",  32'(cnt),   32'd5);
    chk("abort.grant_kept", 32'(grant), 32'h8);
    req = 4'b0001;
    step();
    chk_idle("abort.idle");
    step();
    chk("abort.next_grant", 32'(grant), 32'h1);
    chk("abort.next_owner", 32'(owner), 32'd0);
    step();
    chk("abort.next_done", 32'(done), 32'h1);
    req = '0;
    step();

    // Full range; len changes after grant are ignored.
    do_reset();
    len = 16'h000F;
    req = 4'b0001;
    step();
    chk("full.cnt0", 32'(cnt), 32'd0);
    len = 16'h0002;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("full.cnt",  32'(cnt),  32'(k));
      chk("full.done", 32'(done), 32'd0);
    end
    step();
    chk("full.done_pulse", 32'(done), 32'h1);
    chk("full.cnt_hold",   32'(cnt),  32'd15);
    req = '0;
    step();
    chk_idle("full.end");

    // Reset pulsed mid-run at cnt=7.
    do_reset();
    len = 16'h0F00;
    req = 4'b0100;
    step();
    chk("midrst.owner", 32'(owner), 32'd2);
    for (int k = 0; k < 7; k++) step();
    chk("midrst.cnt7", 32'(cnt), 32'd7);
    rst = 1'b1;
    step();
    chk_idle("midrst.reset");
    chk("midrst.owner0", 32'(owner), 32'd0);
    rst = 1'b0;
    req = '0;
    step();
    chk_idle("midrst.after");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
